// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode/state types, flag indices and instruction field positions
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_HLT   = 4'd1,
        OP_LDI   = 4'd2,
        OP_LD    = 4'd3,
        OP_ST    = 4'd4,
        OP_ADD   = 4'd5,
        OP_SUB   = 4'd6,
        OP_CMP   = 4'd7,
        OP_JMP   = 4'd8,
        OP_JF    = 4'd9,
        OP_IN    = 4'd10,
        OP_OUT   = 4'd11,
        OP_INC   = 4'd12,
        OP_DEC   = 4'd13,
        OP_ILL_E = 4'd14,
        OP_ILL_F = 4'd15
    } opcode_e;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_FETCH_IMM,
        ST_EXEC,
        ST_MEM,
        ST_IO_IN,
        ST_IO_OUT,
        ST_HALT
    } state_e;

    localparam int FLAG_Z      = 0;
    localparam int FLAG_G      = 1;
    localparam int FLAG_C      = 2;
    localparam int FLAG_ALWAYS = 3;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 12;
    localparam int RD_MSB = 11;
    localparam int RD_LSB = 9;
    localparam int RS_MSB = 8;
    localparam int RS_LSB = 6;

    // Opcodes followed by an immediate word at PC+1.
    function automatic logic needs_imm(input opcode_e op);
        return (op == OP_LDI) || (op == OP_JMP) || (op == OP_JF);
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// rtl/cpu_alu.sv - combinational ALU for ADD/SUB/CMP/INC/DEC with Z/G/C flags
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  opcode_e            op,
    input  logic [DATA_W-1:0]  a,
    input  logic [DATA_W-1:0]  b,
    output logic [DATA_W-1:0]  result,
    output logic               z,
    output logic               g,
    output logic               c
);

    localparam logic [DATA_W:0] WIDE_ONE = (DATA_W+1)'(1);

    logic [DATA_W:0] wide;

    // The extra top bit is carry for additions and borrow for subtractions.
    always_comb begin
        wide = '0;
        case (op)
            OP_ADD:         wide = {1'b0, a} + {1'b0, b};
            OP_SUB, OP_CMP: wide = {1'b0, a} - {1'b0, b};
            OP_INC:         wide = {1'b0, a} + WIDE_ONE;
            OP_DEC:         wide = {1'b0, a} - WIDE_ONE;
            default:        wide = '0;
        endcase
    end

    assign result = wide[DATA_W-1:0];
    assign c      = wide[DATA_W];
    assign z      = (result == '0);
    assign g      = (a > b);

endmodule

// File: rtl/param_cpu_core.sv
// rtl/param_cpu_core.sv - parametrised multi-cycle CPU core with memory bus and I/O streams
module param_cpu_core
    import cpu_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              halted,
    output logic              err
);

    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    state_e            state;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] regs [8];
    logic [DATA_W-1:0] imm;
    opcode_e           op_q;
    logic [2:0]        rd_idx;
    logic [2:0]        rs_idx;
    logic              flag_z;
    logic              flag_g;
    logic              flag_c;

    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] alu_result;
    logic              alu_z;
    logic              alu_g;
    logic              alu_c;
    logic [3:0]        flag_vec;
    logic              jf_take;
    opcode_e           fetched_op;

    assign rd_val     = regs[rd_idx];
    assign rs_val     = regs[rs_idx];
    assign fetched_op = opcode_e'(mem_rdata[OP_MSB:OP_LSB]);

    always_comb begin
        flag_vec              = '0;
        flag_vec[FLAG_Z]      = flag_z;
        flag_vec[FLAG_G]      = flag_g;
        flag_vec[FLAG_C]      = flag_c;
        flag_vec[FLAG_ALWAYS] = 1'b1;
    end

    // rs[8:7] selects the flag, rs[6] is the polarity that must match.
    assign jf_take = (flag_vec[rs_idx[2:1]] == rs_idx[0]);

    cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op     (op_q),
        .a      (rd_val),
        .b      (rs_val),
        .result (alu_result),
        .z      (alu_z),
        .g      (alu_g),
        .c      (alu_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_FETCH;
            pc        <= RESET_PC;
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
            imm       <= '0;
            op_q      <= OP_NOP;
            rd_idx    <= '0;
            rs_idx    <= '0;
            flag_z    <= 1'b0;
            flag_g    <= 1'b0;
            flag_c    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            halted    <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    // Outputs are registered, so the first fetch after reset spends one cycle raising mem_req.
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                    end else if (mem_ack) begin
                        op_q   <= fetched_op;
                        rd_idx <= mem_rdata[RD_MSB:RD_LSB];
                        rs_idx <= mem_rdata[RS_MSB:RS_LSB];
                        pc     <= pc + PC_ONE;
                        if (needs_imm(fetched_op)) begin
                            state    <= ST_FETCH_IMM;
                            mem_addr <= pc + PC_ONE;
                        end else begin
                            state   <= ST_EXEC;
                            mem_req <= 1'b0;
                        end
                    end
                end
                ST_FETCH_IMM: begin
                    if (mem_ack) begin
                        imm     <= mem_rdata;
                        pc      <= pc + PC_ONE;
                        mem_req <= 1'b0;
                        state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state    <= ST_FETCH;
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= pc;
                    case (op_q)
                        OP_NOP: ;
                        OP_HLT: begin
                            state   <= ST_HALT;
                            mem_req <= 1'b0;
                            halted  <= 1'b1;
                        end
                        OP_LDI: regs[rd_idx] <= imm;
                        OP_LD: begin
                            state    <= ST_MEM;
                            mem_addr <= rs_val[ADDR_W-1:0];
                        end
                        OP_ST: begin
                            state     <= ST_MEM;
                            mem_we    <= 1'b1;
                            mem_addr  <= rd_val[ADDR_W-1:0];
                            mem_wdata <= rs_val;
                        end
                        OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
                            regs[rd_idx] <= alu_result;
                            flag_z       <= alu_z;
                            flag_c       <= alu_c;
                        end
                        OP_CMP: begin
                            flag_z <= alu_z;
                            flag_g <= alu_g;
                            flag_c <= alu_c;
                        end
                        OP_JMP: begin
                            pc       <= imm[ADDR_W-1:0];
                            mem_addr <= imm[ADDR_W-1:0];
                        end
                        OP_JF: begin
                            if (jf_take) begin
                                pc       <= imm[ADDR_W-1:0];
                                mem_addr <= imm[ADDR_W-1:0];
                            end
                        end
                        OP_IN: begin
                            state    <= ST_IO_IN;
                            mem_req  <= 1'b0;
                            in_ready <= 1'b1;
                        end
                        OP_OUT: begin
                            state     <= ST_IO_OUT;
                            mem_req   <= 1'b0;
                            out_valid <= 1'b1;
                            out_data  <= rs_val;
                        end
                        default: begin
                            state   <= ST_HALT;
                            mem_req <= 1'b0;
                            err     <= 1'b1;
                            halted  <= 1'b1;
                        end
                    endcase
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        if (!mem_we) begin
                            regs[rd_idx] <= mem_rdata;
                        end
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                        state    <= ST_FETCH;
                    end
                end
                ST_IO_IN: begin
                    if (in_valid) begin
                        regs[rd_idx] <= in_data;
                        in_ready     <= 1'b0;
                        mem_req      <= 1'b1;
                        mem_we       <= 1'b0;
                        mem_addr     <= pc;
                        state        <= ST_FETCH;
                    end
                end
                ST_IO_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= pc;
                        state     <= ST_FETCH;
                    end
                end
                ST_HALT: ;
                default: begin
                    state   <= ST_HALT;
                    mem_req <= 1'b0;
                    halted  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_cpu_core.sv
// tb/tb_param_cpu_core.sv - directed self-checking bench for param_cpu_core
module tb_param_cpu_core;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam logic [AW-1:0] BASE = 8'h04;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          halted;
    logic          err;

    logic [DW-1:0] mem [256];
    int            ack_delay = 0;
    int            wait_cnt = 0;
    int            xfer_cnt = 0;
    int            wr_cnt = 0;
    int            out_cnt = 0;
    logic [AW-1:0] last_wr_addr = '0;
    logic [DW-1:0] last_wr_data = '0;

    int n_checks = 0;
    int n_err = 0;

    param_cpu_core #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .RESET_PC (BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .halted    (halted),
        .err       (err)
    );

    always #5 clk = ~clk;

    assign mem_ack   = mem_req && (wait_cnt >= ack_delay);
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (rst || !mem_req || mem_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
        if (!rst && mem_req && mem_ack) begin
            xfer_cnt <= xfer_cnt + 1;
            if (mem_we) begin
                wr_cnt       <= wr_cnt + 1;
                last_wr_addr <= mem_addr;
                last_wr_data <= mem_wdata;
            end
        end
        if (!rst && out_valid && out_ready) out_cnt <= out_cnt + 1;
    end

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs);
        return {op, rd, rs, 6'b0};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    task automatic hold_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic release_reset();
        rst = 1'b0;
    endtask

    task automatic wait_halt(input int max, output bit ok, output int cycles);
        ok = 1'b0;
        cycles = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (halted) begin
                ok = 1'b1;
                break;
            end
            cycles++;
        end
    endtask

    task automatic test_reset();
        ack_delay = 0;
        clear_mem();
        hold_reset();
        n_checks++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
        n_checks++; if (halted !== 1'b0 || err !== 1'b0) begin n_err++; $display("FAIL reset_halted_err: got %b%b expected 00", halted, err); end
        n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL reset_io: got %b%b expected 00", in_ready, out_valid); end
        n_checks++; if (dut.pc !== BASE) begin n_err++; $display("FAIL reset_pc: got %h expected %h", dut.pc, BASE); end
        release_reset();
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== BASE) begin
            n_err++; $display("FAIL first_fetch: got req=%b we=%b addr=%h expected 1 0 %h", mem_req, mem_we, mem_addr, BASE);
        end
    endtask

    task automatic test_timing();
        bit ok;
        int cyc;
        ack_delay = 0;
        hold_reset();
        clear_mem();
        mem[8'h04] = 16'h0000;
        mem[8'h05] = enc(4'd5, 3'd2, 3'd2);
        mem[8'h06] = enc(4'd2, 3'd1, 3'd0);
        mem[8'h07] = 16'h0040;
        mem[8'h08] = enc(4'd3, 3'd3, 3'd1);
        mem[8'h09] = enc(4'd1, 3'd0, 3'd0);
        mem[8'h40] = 16'h1234;
        release_reset();
        wait_halt(200, ok, cyc);
        n_checks++; if (!ok) begin n_err++; $display("FAIL timing_halt: got no halt expected halt"); end
        n_checks++; if (cyc !== 12) begin n_err++; $display("FAIL timing_cycles: got %0d expected 12", cyc); end
        n_checks++; if (dut.regs[3] !== 16'h1234) begin n_err++; $display("FAIL timing_ld: got %h expected 1234", dut.regs[3]); end
        n_checks++; if (dut.flag_z !== 1'b1) begin n_err++; $display("FAIL timing_add_z: got %b expected 1", dut.flag_z); end
        n_checks++; if (dut.pc !== 8'h0A) begin n_err++; $display("FAIL timing_pc: got %h expected 0a", dut.pc); end
    endtask

    task automatic test_branch();
        bit ok;
        int cyc;
        ack_delay = 0;
        hold_reset();
        clear_mem();
        mem[8'h04] = enc(4'd2, 3'd1, 3'd0); mem[8'h05] = 16'd5;
        mem[8'h06] = enc(4'd2, 3'd2, 3'd0); mem[8'h07] = 16'd5;
        mem[8'h08] = enc(4'd7, 3'd1, 3'd2);
        mem[8'h09] = enc(4'd9, 3'd0, 3'b011); mem[8'h0A] = 16'h0030;
        mem[8'h0B] = enc(4'd9, 3'd0, 3'b001); mem[8'h0C] = 16'h0020;
        mem[8'h0D] = enc(4'd1, 3'd0, 3'd0);
        mem[8'h20] = enc(4'd8, 3'd0, 3'd0); mem[8'h21] = 16'h0028;
        mem[8'h28] = enc(4'd1, 3'd0, 3'd0);
        mem[8'h30] = enc(4'd1, 3'd0, 3'd0);
        release_reset();
        wait_halt(200, ok, cyc);
        n_checks++; if (!ok) begin n_err++; $display("FAIL branch_halt: got no halt expected halt"); end
        n_checks++; if (dut.pc !== 8'h29) begin n_err++; $display("FAIL branch_pc: got %h expected 29", dut.pc); end
        n_checks++; if ({dut.flag_z, dut.flag_g, dut.flag_c} !== 3'b100) begin
            n_err++; $display("FAIL branch_flags: got zgc=%b%b%b expected 100", dut.flag_z, dut.flag_g, dut.flag_c);
        end
        n_checks++; if (dut.regs[1] !== 16'd5) begin n_err++; $display("FAIL branch_cmp_keeps_rd: got %h expected 0005", dut.regs[1]); end
    endtask

    task automatic test_arith();
        bit ok;
        int cyc;
        ack_delay = 0;
        hold_reset();
        clear_mem();
        mem[8'h04] = enc(4'd2, 3'd1, 3'd0); mem[8'h05] = 16'h8000;
        mem[8'h06] = enc(4'd2, 3'd2, 3'd0); mem[8'h07] = 16'h8001;
        mem[8'h08] = enc(4'd5, 3'd1, 3'd2);
        mem[8'h09] = enc(4'd2, 3'd4, 3'd0); mem[8'h0A] = 16'd3;
        mem[8'h0B] = enc(4'd2, 3'd5, 3'd0); mem[8'h0C] = 16'd5;
        mem[8'h0D] = enc(4'd6, 3'd4, 3'd5);
        mem[8'h0E] = enc(4'd7, 3'd4, 3'd5);
        mem[8'h0F] = enc(4'd1, 3'd0, 3'd0);
        release_reset();
        wait_halt(200, ok, cyc);
        n_checks++; if (!ok) begin n_err++; $display("FAIL arith_halt: got no halt expected halt"); end
        n_checks++; if (dut.regs[1] !== 16'h0001) begin n_err++; $display("FAIL arith_add: got %h expected 0001", dut.regs[1]); end
        n_checks++; if (dut.regs[4] !== 16'hFFFE) begin n_err++; $display("FAIL arith_sub: got %h expected fffe", dut.regs[4]); end
        n_checks++; if ({dut.flag_z, dut.flag_g, dut.flag_c} !== 3'b010) begin
            n_err++; $display("FAIL arith_cmp_flags: got zgc=%b%b%b expected 010", dut.flag_z, dut.flag_g, dut.flag_c);
        end
    endtask

    task automatic test_inc_dec();
        bit ok;
        int cyc;
        ack_delay = 0;
        hold_reset();
        clear_mem();
        mem[8'h04] = enc(4'd2, 3'd1, 3'd0); mem[8'h05] = 16'hFFFF;
        mem[8'h06] = enc(4'd12, 3'd1, 3'd0);
        mem[8'h07] = enc(4'd1, 3'd0, 3'd0);
        release_reset();
        wait_halt(200, ok, cyc);
        n_checks++; if (!ok || dut.regs[1] !== 16'h0000) begin n_err++; $display("FAIL inc_wrap: got %h expected 0000", dut.regs[1]); end
        n_checks++; if (dut.flag_z !== 1'b1 || dut.flag_c !== 1'b1) begin
            n_err++; $display("FAIL inc_flags: got z=%b c=%b expected z=1 c=1", dut.flag_z, dut.flag_c);
        end
        hold_reset();
        mem[8'h07] = enc(4'd13, 3'd1, 3'd0);
        mem[8'h08] = enc(4'd1, 3'd0, 3'd0);
        release_reset();
        wait_halt(200, ok, cyc);
        n_checks++; if (!ok || dut.regs[1] !== 16'hFFFF) begin n_err++; $display("FAIL dec_wrap: got %h expected ffff", dut.regs[1]); end
        n_checks++; if (dut.flag_z !== 1'b0 || dut.flag_c !== 1'b1) begin
            n_err++; $display("FAIL dec_flags: got z=%b c=%b expected z=0 c=1", dut.flag_z, dut.flag_c);
        end
    endtask

    task automatic test_mem_delay();
        bit            ok;
        int            stab_err;
        int            xfer0;
        int            wr0;
        logic          prev_req;
        logic          prev_ack;
        logic          prev_we;
        logic [AW-1:0] prev_addr;
        logic [DW-1:0] prev_wdata;
        hold_reset();
        clear_mem();
        ack_delay = 3;
        mem[8'h04] = enc(4'd2, 3'd4, 3'd0); mem[8'h05] = 16'h0050;
        mem[8'h06] = enc(4'd3, 3'd3, 3'd4);
        mem[8'h07] = enc(4'd2, 3'd6, 3'd0); mem[8'h08] = 16'h0060;
        mem[8'h09] = enc(4'd4, 3'd6, 3'd3);
        mem[8'h0A] = enc(4'd1, 3'd0, 3'd0);
        mem[8'h50] = 16'hBEEF;
        xfer0 = xfer_cnt;
        wr0 = wr_cnt;
        ok = 1'b0;
        stab_err = 0;
        prev_req = 1'b0;
        prev_ack = 1'b0;
        prev_we = 1'b0;
        prev_addr = '0;
        prev_wdata = '0;
        release_reset();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (prev_req && !prev_ack &&
                (!mem_req || mem_addr !== prev_addr || mem_we !== prev_we || (prev_we && mem_wdata !== prev_wdata)))
                stab_err++;
            prev_req = mem_req;
            prev_ack = mem_ack;
            prev_we = mem_we;
            prev_addr = mem_addr;
            prev_wdata = mem_wdata;
            if (halted) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++; if (!ok) begin n_err++; $display("FAIL delay_halt: got no halt expected halt"); end
        n_checks++; if (stab_err !== 0) begin n_err++; $display("FAIL delay_stable: got %0d unstable cycles expected 0", stab_err); end
        n_checks++; if (dut.regs[3] !== 16'hBEEF) begin n_err++; $display("FAIL delay_ld: got %h expected beef", dut.regs[3]); end
        n_checks++; if (xfer_cnt - xfer0 !== 9) begin n_err++; $display("FAIL delay_xfers: got %0d expected 9", xfer_cnt - xfer0); end
        n_checks++; if (wr_cnt - wr0 !== 1 || last_wr_addr !== 8'h60 || last_wr_data !== 16'hBEEF) begin
            n_err++; $display("FAIL delay_st: got n=%0d addr=%h data=%h expected n=1 addr=60 data=beef", wr_cnt - wr0, last_wr_addr, last_wr_data);
        end
        ack_delay = 0;
    endtask

    task automatic test_io();
        bit ok;
        int cyc;
        int hold_err;
        int o0;
        ack_delay = 0;
        hold_reset();
        clear_mem();
        mem[8'h04] = enc(4'd2, 3'd1, 3'd0); mem[8'h05] = 16'hA5A5;
        mem[8'h06] = enc(4'd11, 3'd0, 3'd1);
        mem[8'h07] = enc(4'd10, 3'd2, 3'd0);
        mem[8'h08] = enc(4'd1, 3'd0, 3'd0);
        out_ready = 1'b0;
        in_valid = 1'b0;
        o0 = out_cnt;
        release_reset();
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1'b1; break; end
        end
        n_checks++; if (!ok) begin n_err++; $display("FAIL io_out_valid: got 0 expected 1 within 50 cycles"); end
        hold_err = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== 16'hA5A5) hold_err++;
        end
        n_checks++; if (hold_err !== 0) begin n_err++; $display("FAIL io_out_hold: got %0d bad cycles expected 0", hold_err); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        n_checks++; if (!ok) begin n_err++; $display("FAIL io_in_ready: got 0 expected 1 within 50 cycles"); end
        hold_err = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (in_ready !== 1'b1) hold_err++;
        end
        n_checks++; if (hold_err !== 0) begin n_err++; $display("FAIL io_in_hold: got %0d bad cycles expected 0", hold_err); end
        in_data = 16'h3C3C;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_halt(100, ok, cyc);
        n_checks++; if (!ok || dut.regs[2] !== 16'h3C3C) begin n_err++; $display("FAIL io_in_data: got %h expected 3c3c", dut.regs[2]); end
        n_checks++; if (out_cnt - o0 !== 1) begin n_err++; $display("FAIL io_out_count: got %0d expected 1", out_cnt - o0); end
    endtask

    task automatic test_illegal();
        bit ok;
        int cyc;
        int bad;
        ack_delay = 0;
        hold_reset();
        clear_mem();
        mem[8'h04] = 16'h0000;
        mem[8'h05] = 16'hE000;
        mem[8'h06] = enc(4'd1, 3'd0, 3'd0);
        release_reset();
        wait_halt(100, ok, cyc);
        n_checks++; if (!ok || err !== 1'b1) begin n_err++; $display("FAIL illegal_err: got halted=%b err=%b expected 1 1", halted, err); end
        n_checks++; if (dut.pc !== 8'h06) begin n_err++; $display("FAIL illegal_pc: got %h expected 06", dut.pc); end
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mem_req || in_ready || out_valid || !halted) bad++;
        end
        n_checks++; if (bad !== 0) begin n_err++; $display("FAIL illegal_quiet: got %0d active cycles expected 0", bad); end
        hold_reset();
        n_checks++; if (err !== 1'b0 || halted !== 1'b0 || dut.pc !== BASE) begin
            n_err++; $display("FAIL illegal_reset: got err=%b halted=%b pc=%h expected 0 0 %h", err, halted, dut.pc, BASE);
        end
        release_reset();
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== BASE) begin
            n_err++; $display("FAIL illegal_resume: got req=%b addr=%h expected 1 %h", mem_req, mem_addr, BASE);
        end
    endtask

    task automatic test_reset_during_st();
        bit ok;
        int wr0;
        int bad;
        hold_reset();
        clear_mem();
        ack_delay = 3;
        mem[8'h04] = enc(4'd2, 3'd1, 3'd0); mem[8'h05] = 16'h0070;
        mem[8'h06] = enc(4'd2, 3'd2, 3'd0); mem[8'h07] = 16'h1111;
        mem[8'h08] = enc(4'd4, 3'd1, 3'd2);
        mem[8'h09] = enc(4'd1, 3'd0, 3'd0);
        wr0 = wr_cnt;
        release_reset();
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mem_req && mem_we) begin ok = 1'b1; break; end
        end
        n_checks++; if (!ok) begin n_err++; $display("FAIL rst_st_pending: got no write request expected one"); end
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mem_req) bad++;
        end
        n_checks++; if (bad !== 0) begin n_err++; $display("FAIL rst_st_req: got %0d cycles with mem_req expected 0", bad); end
        n_checks++; if (wr_cnt - wr0 !== 0) begin n_err++; $display("FAIL rst_st_write: got %0d writes expected 0", wr_cnt - wr0); end
        n_checks++; if (dut.pc !== BASE) begin n_err++; $display("FAIL rst_st_pc: got %h expected %h", dut.pc, BASE); end
        ack_delay = 0;
        release_reset();
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== BASE) begin
            n_err++; $display("FAIL rst_st_resume: got req=%b we=%b addr=%h expected 1 0 %h", mem_req, mem_we, mem_addr, BASE);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_timing();
        test_branch();
        test_arith();
        test_inc_dec();
        test_mem_delay();
        test_io();
        test_illegal();
        test_reset_during_st();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/param_cpu_core.md
PARAM_CPU_CORE -- requirements
Module: param_cpu_core

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the word width (16..32) of registers, memory data and I/O data.
REQ-002 Parameter ADDR_W, default 16, SHALL set the PC and memory address width (8..DATA_W).
REQ-003 Parameter RESET_PC, default 0, SHALL set the PC value loaded on reset.
REQ-004 clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 mem_req  out  1 / mem_we  out  1 / mem_addr  out  ADDR_W / mem_wdata  out  DATA_W: memory request, write enable, address and write data.
REQ-007 mem_ack  in  1 / mem_rdata  in  DATA_W: the transfer completes in any cycle with mem_req&&mem_ack; rdata is valid in that cycle.
REQ-008 in_valid  in  1 / in_ready  out  1 / in_data  in  DATA_W: input stream.
REQ-009 out_valid  out  1 / out_ready  in  1 / out_data  out  DATA_W: output stream.
REQ-010 halted  out  1 (core stopped); err  out  1 (illegal opcode seen).

Function
REQ-011 Instruction word SHALL be op=[15:12], rd=[11:9], rs=[8:6]; 8 registers R0..R7 of DATA_W; flags Z (equal/zero), G (unsigned greater), C (carry/borrow).
REQ-012 Opcodes SHALL be 0 NOP, 1 HLT, 2 LDI rd,#imm, 3 LD rd,[rs], 4 ST [rd],rs, 5 ADD, 6 SUB, 7 CMP, 8 JMP #imm, 9 JF #imm, 10 IN rd, 11 OUT rs, 12 INC rd, 13 DEC rd; 14/15 are illegal.
REQ-013 LDI, JMP and JF SHALL fetch one immediate word at PC+1; every other opcode is one word.
REQ-014 States SHALL be FETCH -> (FETCH_IMM) -> EXEC -> {MEM, IO_IN, IO_OUT} -> FETCH; HALT is terminal until reset.
REQ-015 FETCH/FETCH_IMM/MEM SHALL hold mem_req high with stable addr/we/wdata until the ack cycle; PC increments by 1 (mod 2^ADDR_W) on each fetch ack.
REQ-016 With mem_ack tied high, ADD/SUB/CMP/INC/DEC/NOP SHALL take 2 cycles, LDI/JMP/JF 3, LD/ST 3.
REQ-017 ADD/SUB/INC/DEC SHALL write rd mod 2^DATA_W and set Z on result zero and C on carry-out/borrow; CMP SHALL set Z=(rd==rs), G=(rd>rs) unsigned, C=(rd<rs), and write no register.
REQ-018 Other opcodes SHALL leave flags unchanged.
REQ-019 JF SHALL jump to imm[ADDR_W-1:0] when flag[rs[8:7]] (0=Z, 1=G, 2=C, 3=always) equals rs[6]; otherwise continue at PC+2.
REQ-020 LD/ST SHALL address memory with Rx[ADDR_W-1:0].
REQ-021 IN SHALL hold in_ready high in IO_IN and capture in_data into rd on in_valid&&in_ready.
REQ-022 OUT SHALL hold out_valid high with stable out_data=rs in IO_OUT until out_ready; stalls are unbounded and never time out.
REQ-023 HLT SHALL enter HALT; an illegal opcode SHALL set err and enter HALT; in HALT all request/valid/ready outputs are low and halted=1.

Reset
REQ-024 Reset SHALL set PC=RESET_PC, R0..R7=0, flags=0, state=FETCH, and all outputs low (halted=0, err=0); mem_req asserts in the first cycle after rst deasserts.
REQ-025 Reset asserted mid-transaction SHALL abandon the transaction; an ack arriving in the reset cycle is ignored.

Structure
REQ-026 Package cpu_pkg SHALL hold the opcode enum, state enum, flag index constants and instruction field positions.
REQ-027 Sub-module cpu_alu (combinational, DATA_W-parametrised: op, a, b -> result, Z, G, C) SHALL implement REQ-017.

Verification
REQ-028 mem_ack=1, program LDI R1,#5; LDI R2,#5; CMP R1,R2; JF Z=1,#0x20 -> PC=0x20, Z=1, G=0, C=0.
REQ-029 DATA_W=16: R1=0xFFFF, INC R1 -> R1=0x0000, Z=1, C=1; DEC R1 -> 0xFFFF, C=1.
REQ-030 mem_ack delayed 3 cycles on every request -> mem_addr/mem_we stable throughout; LD R3,[R4] returns mem[R4]; no duplicate transfers.
REQ-031 OUT R1 with out_ready low for 10 cycles -> out_valid held, out_data constant, single transfer; IN R2 with in_valid raised after 5 cycles -> R2=in_data.
REQ-032 Opcode 0xE fetched -> err=1, halted=1, mem_req=0 thereafter; rst pulse -> PC=RESET_PC, err=0, fetch resumes.
REQ-033 rst asserted during a pending ST -> no write occurs after reset; PC=RESET_PC.
